// File: rtl/qpu_itcm_ctrl.sv
// rtl/qpu_itcm_ctrl.sv - ITCM SRAM controller arbitrating ext (loader/debug) and IFU ICB ports
//
// Purpose:
//   Shares one single-port SRAM between the instruction fetch unit and an
//   external (loader/debug) ICB master. At most one SRAM access is made per
//   cycle, and the external port has fixed priority. Each port can have one
//   outstanding response. The response arrives one cycle after the command
//   handshake. Read data is held per port, so a stalled response keeps stable
//   data while the other port keeps using the SRAM.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   ifu_icb_cmd_*          IFU fetch command (valid/ready/addr)
//   ifu_icb_rsp_*          IFU response (valid/ready/rdata)
//   ifu_holdup             SRAM output still holds the last IFU-read word
//   ext_icb_cmd_*          external command (valid/ready/addr/read/wdata/wmask)
//   ext_icb_rsp_*          external response (valid/ready/rdata, 0 for writes)
//   ram_cs/we/addr/wem/din SRAM command side, ram_dout SRAM read data
//
// Configuration:
//   QPU_ITCM_HOLDUP_EN     when defined, builds the holdup flag; otherwise
//                          ifu_holdup is tied to 0.

`ifndef QPU_ITCM_ADDR_WIDTH
`define QPU_ITCM_ADDR_WIDTH 16
`endif
`ifndef QPU_ITCM_DATA_WIDTH
`define QPU_ITCM_DATA_WIDTH 64
`endif

module qpu_itcm_ctrl #(
  parameter int AW = `QPU_ITCM_ADDR_WIDTH,
  parameter int DW = `QPU_ITCM_DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            ifu_icb_cmd_valid,
  output logic            ifu_icb_cmd_ready,
  input  logic [AW-1:0]   ifu_icb_cmd_addr,
  output logic            ifu_icb_rsp_valid,
  input  logic            ifu_icb_rsp_ready,
  output logic [DW-1:0]   ifu_icb_rsp_rdata,
  output logic            ifu_holdup,

  input  logic            ext_icb_cmd_valid,
  output logic            ext_icb_cmd_ready,
  input  logic [AW-1:0]   ext_icb_cmd_addr,
  input  logic            ext_icb_cmd_read,
  input  logic [DW-1:0]   ext_icb_cmd_wdata,
  input  logic [DW/8-1:0] ext_icb_cmd_wmask,
  output logic            ext_icb_rsp_valid,
  input  logic            ext_icb_rsp_ready,
  output logic [DW-1:0]   ext_icb_rsp_rdata,

  output logic            ram_cs,
  output logic            ram_we,
  output logic [AW-4:0]   ram_addr,
  output logic [DW/8-1:0] ram_wem,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  // Per-port response state
  logic          ifu_pend_q, ifu_pend_d;
  logic          ifu_first_q;
  logic [DW-1:0] ifu_hold_q;
  logic          ext_pend_q, ext_pend_d;
  logic          ext_first_q;
  logic          ext_rd_q;
  logic [DW-1:0] ext_hold_q;

  logic ifu_rsp_hs, ext_rsp_hs;
  logic ifu_free, ext_free;
  logic ifu_cmd_hs, ext_cmd_hs;
  logic [DW-1:0] ifu_rdata_raw, ext_rdata_raw;

  // The byte offset within a word is not needed to address the SRAM
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ifu_icb_cmd_addr[2:0], ext_icb_cmd_addr[2:0]};

  // A slot is reusable in the same cycle its response handshakes,
  // which allows back-to-back commands without a bubble.
  assign ifu_rsp_hs = ifu_pend_q & ifu_icb_rsp_ready;
  assign ext_rsp_hs = ext_pend_q & ext_icb_rsp_ready;
  assign ifu_free   = ~ifu_pend_q | ifu_rsp_hs;
  assign ext_free   = ~ext_pend_q | ext_rsp_hs;

  // External port always wins. IFU is locked out whenever ext requests,
  // even if ext itself is stalled by its own full slot.
  assign ext_icb_cmd_ready = ext_icb_cmd_valid & ext_free;
  assign ifu_icb_cmd_ready = ~ext_icb_cmd_valid & ifu_free;

  assign ext_cmd_hs = ext_icb_cmd_valid & ext_icb_cmd_ready;
  assign ifu_cmd_hs = ifu_icb_cmd_valid & ifu_icb_cmd_ready;

  // SRAM command; chip select is also suppressed during reset
  assign ram_cs   = rst_n & (ext_cmd_hs | ifu_cmd_hs);
  assign ram_we   = ram_cs & ext_cmd_hs & ~ext_icb_cmd_read;
  assign ram_wem  = ram_we ? ext_icb_cmd_wmask : '0;
  assign ram_din  = ext_icb_cmd_wdata;
  assign ram_addr = ext_icb_cmd_valid ? ext_icb_cmd_addr[AW-1:3]
                                      : ifu_icb_cmd_addr[AW-1:3];

  assign ifu_pend_d = ifu_cmd_hs | (ifu_pend_q & ~ifu_rsp_hs);
  assign ext_pend_d = ext_cmd_hs | (ext_pend_q & ~ext_rsp_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_pend_q  <= 1'b0;
      ifu_first_q <= 1'b0;
      ext_pend_q  <= 1'b0;
      ext_first_q <= 1'b0;
      ext_rd_q    <= 1'b0;
    end else begin
      ifu_pend_q  <= ifu_pend_d;
      ifu_first_q <= ifu_cmd_hs;
      ext_pend_q  <= ext_pend_d;
      ext_first_q <= ext_cmd_hs;
      if (ext_cmd_hs) begin
        ext_rd_q <= ext_icb_cmd_read;
      end
    end
  end

  // The holding registers carry data only and are not reset. They capture
  // the SRAM output in the first response cycle, because a later access
  // by the other port overwrites ram_dout.
  always_ff @(posedge clk) begin
    if (ifu_first_q) begin
      ifu_hold_q <= ram_dout;
    end
    if (ext_first_q) begin
      ext_hold_q <= ram_dout;
    end
  end

  assign ifu_rdata_raw = ifu_first_q ? ram_dout : ifu_hold_q;
  assign ext_rdata_raw = ext_first_q ? ram_dout : ext_hold_q;

  assign ifu_icb_rsp_valid = ifu_pend_q;
  assign ifu_icb_rsp_rdata = ifu_rdata_raw;
  assign ext_icb_rsp_valid = ext_pend_q;
  assign ext_icb_rsp_rdata = ext_rd_q ? ext_rdata_raw : '0;

`ifdef QPU_ITCM_HOLDUP_EN
  // Arbitration keeps the IFU and ext handshakes mutually exclusive,
  // so set and clear never collide.
  logic holdup_q, holdup_d;

  always_comb begin
    holdup_d = holdup_q;
    if (ifu_cmd_hs) begin
      holdup_d = 1'b1;
    end else if (ext_cmd_hs) begin
      holdup_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdup_q <= 1'b0;
    end else begin
      holdup_q <= holdup_d;
    end
  end

  assign ifu_holdup = holdup_q;
`else
  assign ifu_holdup = 1'b0;
`endif

endmodule

// File: tb/tb_qpu_itcm_ctrl.sv
// tb/tb_qpu_itcm_ctrl.sv - scoreboard bench for qpu_itcm_ctrl
module tb_qpu_itcm_ctrl;

`ifdef QPU_ITCM_HOLDUP_EN
  localparam bit HOLDUP_EN = 1'b1;
`else
  localparam bit HOLDUP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_icb_cmd_valid = 1'b0;
  logic        ifu_icb_cmd_ready;
  logic [15:0] ifu_icb_cmd_addr = '0;
  logic        ifu_icb_rsp_valid;
  logic        ifu_icb_rsp_ready = 1'b1;
  logic [63:0] ifu_icb_rsp_rdata;
  logic        ifu_holdup;
  logic        ext_icb_cmd_valid = 1'b0;
  logic        ext_icb_cmd_ready;
  logic [15:0] ext_icb_cmd_addr = '0;
  logic        ext_icb_cmd_read = 1'b1;
  logic [63:0] ext_icb_cmd_wdata = '0;
  logic [7:0]  ext_icb_cmd_wmask = '0;
  logic        ext_icb_rsp_valid;
  logic        ext_icb_rsp_ready = 1'b1;
  logic [63:0] ext_icb_rsp_rdata;
  logic        ram_cs;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wem;
  logic [63:0] ram_din;
  logic [63:0] ram_dout = '0;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] ifu_q[$];
  logic [63:0] ext_q[$];
  logic [63:0] mem[0:63];

  always #5 clk = ~clk;

  qpu_itcm_ctrl #(.AW(16), .DW(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_icb_cmd_valid(ifu_icb_cmd_valid), .ifu_icb_cmd_ready(ifu_icb_cmd_ready),
    .ifu_icb_cmd_addr(ifu_icb_cmd_addr), .ifu_icb_rsp_valid(ifu_icb_rsp_valid),
    .ifu_icb_rsp_ready(ifu_icb_rsp_ready), .ifu_icb_rsp_rdata(ifu_icb_rsp_rdata),
    .ifu_holdup(ifu_holdup),
    .ext_icb_cmd_valid(ext_icb_cmd_valid), .ext_icb_cmd_ready(ext_icb_cmd_ready),
    .ext_icb_cmd_addr(ext_icb_cmd_addr), .ext_icb_cmd_read(ext_icb_cmd_read),
    .ext_icb_cmd_wdata(ext_icb_cmd_wdata), .ext_icb_cmd_wmask(ext_icb_cmd_wmask),
    .ext_icb_rsp_valid(ext_icb_rsp_valid), .ext_icb_rsp_ready(ext_icb_rsp_ready),
    .ext_icb_rsp_rdata(ext_icb_rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // SRAM model: registered read, output held until the next chip select
  always @(posedge clk) begin
    if (ram_cs) begin
      ram_dout <= mem[ram_addr[5:0]];
      if (ram_we) begin
        for (int b = 0; b < 8; b++) begin
          if (ram_wem[b]) mem[ram_addr[5:0]][b*8 +: 8] = ram_din[b*8 +: 8];
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a response is shown, its data must equal the
  // oldest expected entry; the entry retires on the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifu_icb_rsp_valid) begin
        if (ifu_q.size() == 0) check("ifu_rsp_unexpected", 64'd1, 64'd0);
        else begin
          check("ifu_rsp_rdata", ifu_icb_rsp_rdata, ifu_q[0]);
          if (ifu_icb_rsp_ready) void'(ifu_q.pop_front());
        end
      end
      if (ext_icb_rsp_valid) begin
        if (ext_q.size() == 0) check("ext_rsp_unexpected", 64'd1, 64'd0);
        else begin
          check("ext_rsp_rdata", ext_icb_rsp_rdata, ext_q[0]);
          if (ext_icb_rsp_ready) void'(ext_q.pop_front());
        end
      end
    end
  end

  // Presents an IFU command and leaves valid high after the handshake, so
  // consecutive calls issue back-to-back.
  task automatic ifu_issue(input logic [15:0] a, input logic [63:0] exp);
    int n = 0;
    ifu_icb_cmd_valid = 1'b1;
    ifu_icb_cmd_addr  = a;
    @(negedge clk);
    while (!ifu_icb_cmd_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("ifu_cmd_ready", {63'd0, ifu_icb_cmd_ready}, 64'd1);
    check("ifu_ram_cs", {63'd0, ram_cs}, 64'd1);
    check("ifu_ram_addr", {51'd0, ram_addr}, {48'd0, a} >> 3);
    check("ifu_ram_we", {63'd0, ram_we}, 64'd0);
    ifu_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic ext_issue(input logic rd, input logic [15:0] a, input logic [63:0] wd,
                           input logic [7:0] wm, input logic [63:0] exp);
    int n = 0;
    ext_icb_cmd_valid = 1'b1;
    ext_icb_cmd_read  = rd;
    ext_icb_cmd_addr  = a;
    ext_icb_cmd_wdata = wd;
    ext_icb_cmd_wmask = wm;
    @(negedge clk);
    while (!ext_icb_cmd_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("ext_cmd_ready", {63'd0, ext_icb_cmd_ready}, 64'd1);
    check("ext_ram_addr", {51'd0, ram_addr}, {48'd0, a} >> 3);
    check("ext_ram_we", {63'd0, ram_we}, {63'd0, ~rd});
    check("ext_ram_wem", {56'd0, ram_wem}, rd ? 64'd0 : {56'd0, wm});
    ext_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 64'h5555_0000_0000_0000 | 64'(i);
    mem[0] = 64'h0123_4567_89AB_CDEF;
    mem[1] = 64'h0;
    mem[2] = 64'h1122_3344_5566_7788;
    mem[3] = 64'hDEAD_BEEF_CAFE_F00D;
    mem[4] = 64'h0F0F_0F0F_0F0F_0F0F;
    mem[5] = 64'hA5A5_A5A5_A5A5_A5A5;

    // Reset: no chip select even with a pending request, slots free
    ifu_icb_cmd_valid = 1'b1;
    ifu_icb_cmd_addr  = 16'h10;
    repeat (2) @(negedge clk);
    check("rst_ram_cs", {63'd0, ram_cs}, 64'd0);
    check("rst_ifu_cmd_ready", {63'd0, ifu_icb_cmd_ready}, 64'd1);
    check("rst_ifu_rsp_valid", {63'd0, ifu_icb_rsp_valid}, 64'd0);
    check("rst_ext_rsp_valid", {63'd0, ext_icb_rsp_valid}, 64'd0);
    check("rst_holdup", {63'd0, ifu_holdup}, 64'd0);
    ifu_icb_cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single IFU read of word 2
    ifu_issue(16'h10, 64'h1122_3344_5566_7788);
    ifu_icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("a_ifu_rsp_valid", {63'd0, ifu_icb_rsp_valid}, 64'd1);
    check("a_holdup", {63'd0, ifu_holdup}, {63'd0, HOLDUP_EN});
    @(posedge clk); #1;

    // Simultaneous requests: ext first, IFU next cycle
    ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 16'h0;
    ext_icb_cmd_valid = 1'b1; ext_icb_cmd_read = 1'b1; ext_icb_cmd_addr = 16'h18;
    @(negedge clk);
    check("b_ext_ready", {63'd0, ext_icb_cmd_ready}, 64'd1);
    check("b_ifu_ready", {63'd0, ifu_icb_cmd_ready}, 64'd0);
    check("b_ram_addr_ext", {51'd0, ram_addr}, 64'd3);
    ext_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
    @(posedge clk); #1;
    ext_icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("b_ifu_ready2", {63'd0, ifu_icb_cmd_ready}, 64'd1);
    check("b_ram_addr_ifu", {51'd0, ram_addr}, 64'd0);
    check("b_holdup_fall", {63'd0, ifu_holdup}, 64'd0);
    ifu_q.push_back(64'h0123_4567_89AB_CDEF);
    @(posedge clk); #1;
    ifu_icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("b_holdup_rise", {63'd0, ifu_holdup}, {63'd0, HOLDUP_EN});
    @(posedge clk); #1;

    // Stalled IFU response while ext reads three other words
    ifu_icb_rsp_ready = 1'b0;
    ifu_issue(16'h10, 64'h1122_3344_5566_7788);
    ifu_icb_cmd_valid = 1'b0;
    ext_issue(1'b1, 16'h00, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF);
    ext_issue(1'b1, 16'h18, 64'd0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D);
    ext_issue(1'b1, 16'h20, 64'd0, 8'h00, 64'h0F0F_0F0F_0F0F_0F0F);
    ext_icb_cmd_valid = 1'b0;
    ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 16'h28;
    @(negedge clk);
    check("c_ifu_ready_blocked", {63'd0, ifu_icb_cmd_ready}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("c_ifu_ready_blocked2", {63'd0, ifu_icb_cmd_ready}, 64'd0);
    @(posedge clk); #1;
    ifu_icb_rsp_ready = 1'b1;
    ifu_issue(16'h28, 64'hA5A5_A5A5_A5A5_A5A5);
    ifu_icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("c_b2b_rsp_valid", {63'd0, ifu_icb_rsp_valid}, 64'd1);
    @(posedge clk); #1;

    // Masked write of the low four bytes, then IFU reads it back
    ext_issue(1'b0, 16'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'd0);
    ext_icb_cmd_valid = 1'b0;
    ifu_issue(16'h08, 64'h0000_0000_FFFF_FFFF);
    ifu_icb_cmd_valid = 1'b0;
    @(posedge clk); #1;

    // Streaming IFU reads: a response every cycle
    ifu_issue(16'h00, 64'h0123_4567_89AB_CDEF);
    ifu_issue(16'h08, 64'h0000_0000_FFFF_FFFF);
    check("e_stream_rsp1", {63'd0, ifu_icb_rsp_valid}, 64'd1);
    ifu_issue(16'h10, 64'h1122_3344_5566_7788);
    ifu_icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("e_stream_rsp3", {63'd0, ifu_icb_rsp_valid}, 64'd1);
    @(posedge clk); #1;

    // Reset in the middle of a pending response
    ifu_icb_rsp_ready = 1'b0;
    ifu_issue(16'h20, 64'h0F0F_0F0F_0F0F_0F0F);
    ifu_icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("f_pending", {63'd0, ifu_icb_rsp_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("f_rst_rsp_valid", {63'd0, ifu_icb_rsp_valid}, 64'd0);
    check("f_rst_holdup", {63'd0, ifu_holdup}, 64'd0);
    check("f_rst_ifu_ready", {63'd0, ifu_icb_cmd_ready}, 64'd1);
    ifu_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    ifu_icb_rsp_ready = 1'b1;
    @(posedge clk); #1;
    ifu_issue(16'h10, 64'h1122_3344_5566_7788);
    ifu_icb_cmd_valid = 1'b0;
    @(negedge clk);
    check("f_post_rsp_valid", {63'd0, ifu_icb_rsp_valid}, 64'd1);
    check("f_post_holdup", {63'd0, ifu_holdup}, {63'd0, HOLDUP_EN});

    repeat (3) @(posedge clk);
    #1;
    check("ifu_q_drained", 64'(ifu_q.size()), 64'd0);
    check("ext_q_drained", 64'(ext_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
